// File: rtl/hilo_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operand width,
// op encodings and the sequencer state type.
package hilo_pkg;
   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;
endpackage

// File: rtl/ex_hilo_muldiv_if.sv
// Bundle between ID/EX and the multiply/divide unit: op/operands and
// mfhi/mflo requests in, HI/LO values and busy/stall out.
interface ex_hilo_muldiv_if;
   import hilo_pkg::*;
   logic [2:0]      op;
   logic [XLEN-1:0] busA;
   logic [XLEN-1:0] busB;
   logic            rd_hi;
   logic            rd_lo;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            stall;

   modport master (output op, busA, busB, rd_hi, rd_lo,
                   input  hi, lo, busy, stall);
   modport slave  (input  op, busA, busB, rd_hi, rd_lo,
                   output hi, lo, busy, stall);
endinterface

// File: rtl/ex_hilo_muldiv_iter.sv
// Shared iterative datapath: one shift-add multiply step or one restoring
// divide step per enabled edge, operating on unsigned magnitudes.
module muldiv_iter
   import hilo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              step_i,
   input  logic              div_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic              last_o
);
   // acc_q upper half: running product high word / partial remainder.
   // acc_q lower half: multiplier bits still to consume / dividend-then-quotient.
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;
   logic              ge;

   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      shifted = acc_q[2*XLEN-1:XLEN-1];
      diff    = shifted - {1'b0, opnd_q};
      ge      = ~diff[XLEN];

      acc_d  = acc_q;
      opnd_d = opnd_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      if (start_i) begin
         acc_d  = {{XLEN{1'b0}}, (div_i ? a_i : b_i)};
         opnd_d = div_i ? b_i : a_i;
         div_d  = div_i;
         cnt_d  = '0;
      end else if (step_i) begin
         if (div_q)
            acc_d = {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc_q[XLEN-2:0], ge};
         else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
      end
   end

   assign acc_o  = acc_q;
   assign last_o = step_i && (cnt_q == CNT_W'(XLEN-1));
endmodule

// File: rtl/ex_hilo_muldiv.sv
// EX-stage multiply/divide unit: sequencer FSM, sign bookkeeping, HI/LO
// architectural registers and the pipeline stall request.
module ex_hilo_muldiv
   import hilo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   ex_hilo_muldiv_if.slave  mdu
);
   state_e            state_q, state_d;
   logic              start, busy, op_valid;
   logic              is_div, is_signed, sign_a, sign_b;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [2*XLEN-1:0] acc, prod;
   logic              last;
   logic [XLEN-1:0]   res_hi, res_lo;
   logic [XLEN-1:0]   hi_q, lo_q, a_raw_q;
   logic              div_q, neg_lo_q, neg_hi_q, div0_q;

   assign is_div    = (mdu.op == OP_DIV)  || (mdu.op == OP_DIVU);
   assign is_signed = (mdu.op == OP_MULT) || (mdu.op == OP_DIV);
   assign sign_a    = is_signed & mdu.busA[XLEN-1];
   assign sign_b    = is_signed & mdu.busB[XLEN-1];
   assign a_abs     = sign_a ? -mdu.busA : mdu.busA;
   assign b_abs     = sign_b ? -mdu.busB : mdu.busB;

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: if (mdu.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            start   = 1'b1;
            state_d = RUN;
         end
         RUN:  if (last) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   muldiv_iter u_iter (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .step_i  (state_q == RUN),
      .div_i   (is_div),
      .a_i     (a_abs),
      .b_i     (b_abs),
      .acc_o   (acc),
      .last_o  (last)
   );

   // Divide-by-zero is overridden at FIX rather than special-cased in the
   // datapath, so latency stays identical for every op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
         a_raw_q  <= '0;
      end else if (start) begin
         div_q    <= is_div;
         neg_lo_q <= sign_a ^ sign_b;
         neg_hi_q <= is_div ? sign_a : (sign_a ^ sign_b);
         div0_q   <= is_div && (mdu.busB == '0);
         a_raw_q  <= mdu.busA;
      end
   end

   always_comb begin
      prod   = neg_lo_q ? -acc : acc;
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
      if (div_q) begin
         res_lo = neg_lo_q ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
         res_hi = neg_hi_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
         if (div0_q) begin
            res_lo = '1;
            res_hi = a_raw_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state_q == FIX) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (state_q == IDLE) begin
         if (mdu.op == OP_MTHI) hi_q <= mdu.busA;
         if (mdu.op == OP_MTLO) lo_q <= mdu.busA;
      end
   end

   assign busy      = (state_q != IDLE);
   assign op_valid  = (mdu.op != OP_NONE) && (mdu.op != OP_RSVD);
   assign mdu.busy  = busy;
   assign mdu.stall = busy & (op_valid | mdu.rd_hi | mdu.rd_lo);
   assign mdu.hi    = hi_q;
   assign mdu.lo    = lo_q;
endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Directed vector bench for ex_hilo_muldiv: table of mult/div results plus
// hand-written stall, mthi/mtlo, back-to-back and reset sequences.
module tb_ex_hilo_muldiv;
   import hilo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_hilo_muldiv_if mdu ();
   ex_hilo_muldiv dut (.clk(clk), .rst(rst), .mdu(mdu));

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[12];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one op for a single accepted edge, then waits out busy.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles);
      int cnt;
      @(negedge clk);
      mdu.op = op; mdu.busA = a; mdu.busB = b;
      @(negedge clk);
      mdu.op = OP_NONE;
      cnt = 0;
      while (mdu.busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      busy_cycles = cnt;
   endtask

   initial begin
      int bc, st;
      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      vecs[5]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE};
      vecs[6]  = '{OP_MULT,  32'd6,        32'd7,        32'd0,        32'd42};
      vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
      vecs[9]  = '{OP_DIVU,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
      vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
      vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};

      mdu.op = OP_NONE; mdu.busA = '0; mdu.busB = '0; mdu.rd_hi = 1'b0; mdu.rd_lo = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_hi", mdu.hi, 32'd0);
      chk("reset_lo", mdu.lo, 32'd0);
      chk("reset_busy", {31'd0, mdu.busy}, 32'd0);
      chk("reset_stall", {31'd0, mdu.stall}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
         chk($sformatf("vec%0d_busy_cycles", i), bc, 32'd33);
         chk($sformatf("vec%0d_hi", i), mdu.hi, vecs[i].exp_hi);
         chk($sformatf("vec%0d_lo", i), mdu.lo, vecs[i].exp_lo);
      end

      // MULTU followed by mflo: mflo stalls for the whole sequence.
      @(negedge clk);
      mdu.op = OP_MULTU; mdu.busA = 32'hFFFFFFFF; mdu.busB = 32'd2;
      @(negedge clk);
      mdu.op = OP_NONE; mdu.rd_lo = 1'b1;
      st = 0;
      for (int k = 0; k < 100 && mdu.busy; k++) begin
         if (mdu.stall) st++;
         @(negedge clk);
      end
      chk("mflo_stall_cycles", st, 32'd33);
      chk("mflo_stall_after", {31'd0, mdu.stall}, 32'd0);
      chk("mflo_value", mdu.lo, 32'hFFFFFFFE);
      mdu.rd_lo = 1'b0;

      // MTHI then mfhi next cycle.
      mdu.op = OP_MTHI; mdu.busA = 32'h1234;
      chk("mthi_no_stall", {31'd0, mdu.stall}, 32'd0);
      @(negedge clk);
      mdu.op = OP_NONE; mdu.rd_hi = 1'b1;
      chk("mfhi_value", mdu.hi, 32'h1234);
      chk("mfhi_no_stall", {31'd0, mdu.stall}, 32'd0);
      chk("mthi_lo_kept", mdu.lo, 32'hFFFFFFFE);
      mdu.rd_hi = 1'b0;

      // MTLO presented during busy is held off until after completion.
      @(negedge clk);
      mdu.op = OP_MULT; mdu.busA = 32'd6; mdu.busB = 32'd7;
      @(negedge clk);
      mdu.op = OP_MTLO; mdu.busA = 32'hABCD;
      chk("mtlo_stalled", {31'd0, mdu.stall}, 32'd1);
      bc = 0;
      while (mdu.busy && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      chk("mtlo_wait_cycles", bc, 32'd33);
      chk("mtlo_mult_lo", mdu.lo, 32'd42);
      chk("mtlo_mult_hi", mdu.hi, 32'd0);
      @(negedge clk);
      mdu.op = OP_NONE;
      chk("mtlo_applied", mdu.lo, 32'hABCD);
      chk("mtlo_hi_kept", mdu.hi, 32'd0);

      // Back-to-back: second op held through busy, accepted right after.
      @(negedge clk);
      mdu.op = OP_DIVU; mdu.busA = 32'd100; mdu.busB = 32'd7;
      @(negedge clk);
      mdu.op = OP_MULTU; mdu.busA = 32'd3; mdu.busB = 32'd5;
      bc = 0;
      while (mdu.busy && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      chk("b2b_first_lo", mdu.lo, 32'd14);
      chk("b2b_first_hi", mdu.hi, 32'd2);
      @(negedge clk);
      mdu.op = OP_NONE;
      chk("b2b_second_busy", {31'd0, mdu.busy}, 32'd1);
      bc = 0;
      while (mdu.busy && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      chk("b2b_second_cycles", bc, 32'd33);
      chk("b2b_second_lo", mdu.lo, 32'd15);
      chk("b2b_second_hi", mdu.hi, 32'd0);

      // Reset mid-RUN aborts and clears HI/LO.
      @(negedge clk);
      mdu.op = OP_MTHI; mdu.busA = 32'h5555;
      @(negedge clk);
      mdu.op = OP_MULT; mdu.busA = 32'd5; mdu.busB = 32'd5;
      @(negedge clk);
      mdu.op = OP_NONE;
      repeat (10) @(negedge clk);
      chk("pre_reset_busy", {31'd0, mdu.busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrun_reset_hi", mdu.hi, 32'd0);
      chk("midrun_reset_lo", mdu.lo, 32'd0);
      chk("midrun_reset_busy", {31'd0, mdu.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_MULT, 32'd6, 32'd7, bc);
      chk("post_reset_cycles", bc, 32'd33);
      chk("post_reset_lo", mdu.lo, 32'd42);
      chk("post_reset_hi", mdu.hi, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
